dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single data-memory port of the `memory` module. It shares that port between the CPU datapath load/store path and an auxiliary master, such as a program loader or debug/DMA engine. It serialises requests and sequences each access through issue and response cycles that match the memory's one-cycle synchronous read. It sits between the requesters and `memory`'s `dmem_*` and `funct3` inputs.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
package dmem_arb_pkg;

    // Width of the access-register fields; the arbiter's ADDR_W/DATA_W
    // must not exceed these.
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_AUX = 1'b1
    } master_e;

    // One memory access captured at grant time.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the master not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Pick the lone requester, or alternate against last_grant on a tie.
    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single synchronous-read data-memory port between the CPU
// load/store path and an auxiliary master. Each access runs
// IDLE -> ISSUE (address/write presented) -> RESP (read data back, ack).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    input  logic [2:0]        aux_funct3,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_e state_q, state_d;
    master_e    owner_q, owner_d;
    master_e    last_grant_q, last_grant_d;
    mem_req_t   acc_q, acc_d;

    logic       grant_valid;
    logic       grant_id;

    logic [1:0]        ack_bus;
    logic [DATA_W-1:0] rdata_bus [2];

    rr_pick2 u_pick (
        .req         ({aux_req, cpu_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Next-state logic: grant and latch in IDLE, sequence ISSUE/RESP.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    acc_d.we     = grant_id ? aux_we : cpu_we;
                    acc_d.addr   = ARB_ADDR_W'(grant_id ? aux_addr : cpu_addr);
                    acc_d.wdata  = ARB_DATA_W'(grant_id ? aux_wdata : cpu_wdata);
                    acc_d.funct3 = grant_id ? aux_funct3 : cpu_funct3;
                    owner_d      = master_e'(grant_id);
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state, owner, round-robin history and access register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= MST_CPU;
            last_grant_q <= MST_AUX;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
        end
    end

    // Per-master ack decode and load-data register with same-cycle bypass.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mst
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic              is_owner;

        assign is_owner    = (owner_q == ((gi == 0) ? MST_CPU : MST_AUX));
        assign ack_bus[gi] = (state_q == RESP) && is_owner;

        // Capture memory data on the owner's load response, else hold.
        always_comb begin
            rdata_d = rdata_q;
            if (ack_bus[gi] && !acc_q.we) begin
                rdata_d = mem_rdata;
            end
        end

        // Load-data holding register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_bus[gi] = rdata_d;
    end

    assign cpu_ack    = ack_bus[0];
    assign aux_ack    = ack_bus[1];
    assign cpu_rdata  = rdata_bus[0];
    assign aux_rdata  = rdata_bus[1];

    // Write enable only in ISSUE, so a reset there removes it at once.
    assign mem_wren   = (state_q == ISSUE) && acc_q.we;
    assign mem_addr   = acc_q.addr[ADDR_W-1:0];
    assign mem_wdata  = acc_q.wdata[DATA_W-1:0];
    assign mem_funct3 = acc_q.funct3;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner cases and a
// randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, aux_req, aux_we;
    logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
    logic [2:0]  cpu_funct3, aux_funct3;
    logic        cpu_ack, aux_ack, mem_wren, busy, owner;
    logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_funct3(aux_funct3),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // Synchronous-read memory, word index from addr[9:2].
    logic [31:0] ram [256];
    logic        ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wren) ram[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string nm, input logic act, input logic exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        ar, aw;
        logic [31:0] aa, ad;
        logic        e_wren, e_cack, e_aack, e_busy, e_own;
        logic [31:0] e_addr, e_crd, e_ard;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] KK = 32'h12345678;
    localparam logic [31:0] A0 = 32'h2000;
    localparam logic [31:0] A4 = 32'h2004;
    localparam logic [31:0] Z  = 32'h0;

    vec_t tbl [13];

    // Transaction-level model state for the random run.
    logic [31:0] gmem [256];
    logic [31:0] mrd [2];
    logic        pend [2];
    logic        p_we [2];
    logic [31:0] p_addr [2], p_wdata [2];
    logic [2:0]  p_f3 [2];

    initial begin
        int          wren_slot, ack_slot, free_slot;
        logic        e_own, e_we, last_g, own_vis, bsy, g;
        logic [31:0] e_addr, e_wdata, r;
        logic [2:0]  e_f3;
        logic [7:0]  idx;

        // Directed vectors: row inputs are sampled at the next edge and the
        // expected fields describe the outputs right after that edge.
        tbl[0]  = '{1'b1,1'b1,A0,DB, 1'b1,1'b1,A4,KK, 1'b1,1'b0,1'b0,1'b1,1'b0, A0,Z,Z};
        tbl[1]  = '{1'b1,1'b1,A0,DB, 1'b1,1'b1,A4,KK, 1'b0,1'b1,1'b0,1'b1,1'b0, A0,Z,Z};
        tbl[2]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b1,A4,KK, 1'b0,1'b0,1'b0,1'b0,1'b0, Z,Z,Z};
        tbl[3]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b1,A4,KK, 1'b1,1'b0,1'b0,1'b1,1'b1, A4,Z,Z};
        tbl[4]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b1,32'h3000,KK, 1'b0,1'b0,1'b1,1'b1,1'b1, A4,Z,Z};
        tbl[5]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b0,A4,Z,  1'b0,1'b0,1'b0,1'b0,1'b1, Z,Z,Z};
        tbl[6]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b0,A4,Z,  1'b0,1'b0,1'b0,1'b1,1'b0, A0,Z,Z};
        tbl[7]  = '{1'b1,1'b0,A0,Z,  1'b1,1'b0,A4,Z,  1'b0,1'b1,1'b0,1'b1,1'b0, A0,DB,Z};
        tbl[8]  = '{1'b0,1'b0,Z,Z,   1'b1,1'b0,A4,Z,  1'b0,1'b0,1'b0,1'b0,1'b0, Z,DB,Z};
        tbl[9]  = '{1'b0,1'b0,Z,Z,   1'b1,1'b0,A4,Z,  1'b0,1'b0,1'b0,1'b1,1'b1, A4,DB,Z};
        tbl[10] = '{1'b0,1'b0,Z,Z,   1'b1,1'b0,A4,Z,  1'b0,1'b0,1'b1,1'b1,1'b1, A4,DB,KK};
        tbl[11] = '{1'b0,1'b0,Z,Z,   1'b0,1'b0,Z,Z,   1'b0,1'b0,1'b0,1'b0,1'b1, Z,DB,KK};
        tbl[12] = '{1'b0,1'b0,Z,Z,   1'b0,1'b0,Z,Z,   1'b0,1'b0,1'b0,1'b0,1'b1, Z,DB,KK};

        // Reset held with both masters requesting: everything stays at 0.
        reset = 1'b0; ram_clr = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = A0; cpu_wdata = DB; cpu_funct3 = 3'b010;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = A4; aux_wdata = KK; aux_funct3 = 3'b010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk1("rst_wren", mem_wren, 1'b0);
            chk1("rst_cpu_ack", cpu_ack, 1'b0);
            chk1("rst_aux_ack", aux_ack, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_owner", owner, 1'b0);
            chk32("rst_addr", mem_addr, Z);
            chk32("rst_wdata", mem_wdata, Z);
            chk32("rst_f3", {29'd0, mem_funct3}, Z);
            chk32("rst_cpu_rdata", cpu_rdata, Z);
            chk32("rst_aux_rdata", aux_rdata, Z);
        end
        reset = 1'b1; ram_clr = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            aux_req = tbl[i].ar; aux_we = tbl[i].aw; aux_addr = tbl[i].aa; aux_wdata = tbl[i].ad;
            @(negedge clk);
            chk1($sformatf("v%0d_wren", i), mem_wren, tbl[i].e_wren);
            chk1($sformatf("v%0d_cpu_ack", i), cpu_ack, tbl[i].e_cack);
            chk1($sformatf("v%0d_aux_ack", i), aux_ack, tbl[i].e_aack);
            chk1($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk1($sformatf("v%0d_owner", i), owner, tbl[i].e_own);
            chk32($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            chk32($sformatf("v%0d_aux_rdata", i), aux_rdata, tbl[i].e_ard);
            if (tbl[i].e_busy) chk32($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
            $display("vec %0d: cpu_ack=%b aux_ack=%b wren=%b owner=%b addr=%h",
                     i, cpu_ack, aux_ack, mem_wren, owner, mem_addr);
        end

        // Reset in the middle of a store's ISSUE cycle.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h2008; cpu_wdata = 32'h55AA55AA;
        aux_req = 1'b0;
        @(posedge clk); #2;
        chk1("mid_wren_before", mem_wren, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk1("mid_wren_async", mem_wren, 1'b0);
        chk1("mid_busy_async", busy, 1'b0);
        chk1("mid_cpu_ack", cpu_ack, 1'b0);
        @(negedge clk);
        cpu_req = 1'b0;
        chk1("mid_cpu_ack_hold", cpu_ack, 1'b0);
        @(negedge clk);
        chk1("mid_cpu_ack_hold2", cpu_ack, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("mid_busy_after", busy, 1'b0);
        chk32("mid_cpu_rdata", cpu_rdata, Z);
        chk32("mid_aux_rdata", aux_rdata, Z);
        $display("mid-issue reset: wren dropped, no ack");

        // Randomized run. Memory contents known so far: the two table stores.
        for (int i = 0; i < 256; i++) gmem[i] = '0;
        gmem[0] = DB; gmem[1] = KK;
        mrd[0] = '0; mrd[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_g = 1'b1; own_vis = 1'b0;
        wren_slot = -10; ack_slot = -10; free_slot = 0;
        e_own = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_f3 = '0;

        for (int slot = 0; slot < 900; slot++) begin
            @(negedge clk);
            if (slot == wren_slot) begin
                own_vis = e_own;
                // The winner's inputs now wander; the access must not follow.
                r = $urandom;
                p_addr[e_own]  = r;
                p_wdata[e_own] = $urandom;
                p_f3[e_own]    = r[2:0];
            end
            bsy = (slot == wren_slot) || (slot == ack_slot);
            if (slot == ack_slot) begin
                idx = e_addr[9:2];
                if (e_we) gmem[idx] = e_wdata;
                else      mrd[e_own] = gmem[idx];
                last_g = e_own;
                pend[e_own] = 1'b0;
                $display("txn @%0d: %s %s addr=%h data=%h", slot,
                         e_own ? "AUX" : "CPU", e_we ? "st" : "ld", e_addr,
                         e_we ? e_wdata : gmem[idx]);
            end
            chk1("r_wren", mem_wren, (slot == wren_slot) && e_we);
            chk1("r_cpu_ack", cpu_ack, (slot == ack_slot) && !e_own);
            chk1("r_aux_ack", aux_ack, (slot == ack_slot) && e_own);
            chk1("r_busy", busy, bsy);
            chk1("r_owner", owner, own_vis);
            chk32("r_cpu_rdata", cpu_rdata, mrd[0]);
            chk32("r_aux_rdata", aux_rdata, mrd[1]);
            if (bsy) begin
                chk32("r_addr", mem_addr, e_addr);
                chk32("r_wdata", mem_wdata, e_wdata);
                chk32("r_f3", {29'd0, mem_funct3}, {29'd0, e_f3});
            end

            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 3) != 0) begin
                    r = $urandom;
                    pend[m]    = 1'b1;
                    p_we[m]    = r[0];
                    p_f3[m]    = r[3:1];
                    p_addr[m]  = {r[31:10], 5'd0, 3'($urandom_range(0, 7)), 2'b00};
                    p_wdata[m] = $urandom;
                end
            end

            if (slot >= free_slot && (pend[0] || pend[1])) begin
                g = (pend[0] && pend[1]) ? ~last_g : pend[1];
                e_own = g; e_we = p_we[g]; e_addr = p_addr[g];
                e_wdata = p_wdata[g]; e_f3 = p_f3[g];
                wren_slot = slot + 1; ack_slot = slot + 2; free_slot = slot + 3;
            end

            cpu_req = pend[0]; cpu_we = p_we[0]; cpu_addr = p_addr[0];
            cpu_wdata = p_wdata[0]; cpu_funct3 = p_f3[0];
            aux_req = pend[1]; aux_we = p_we[1]; aux_addr = p_addr[1];
            aux_wdata = p_wdata[1]; aux_funct3 = p_f3[1];
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
